// File: rtl/down_counter.sv
// ============================================================================
// Module      : down_counter
// Description : Loadable down-counter with expiry tick, one-shot or periodic
//               auto-reload operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter #(
    parameter int MAX_COUNTER_VALUE = 160,
    parameter int AUTO_RELOAD       = 0,
    localparam int W                = $clog2(MAX_COUNTER_VALUE + 1)
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    input  logic         enable_i,
    output logic [W-1:0] counter_val_o,
    output logic         busy_o,
    output logic         finished_o,
    output logic         tick_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [W:0]   c_max_ext = (W+1)'(MAX_COUNTER_VALUE);
    localparam logic [W-1:0] c_one     = W'(1);
    localparam logic [W-1:0] c_zero    = '0;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] r_reload;
    logic [W-1:0] w_reload_nxt;
    logic         r_tick;
    logic         w_tick_nxt;
    logic [W:0]   w_load_ext;
    logic [W-1:0] w_load_sat;

    // One extra bit on the compare so no input value can alias below the limit.
    assign w_load_ext = {1'b0, load_value_i};
    assign w_load_sat = (w_load_ext > c_max_ext) ? c_max_ext[W-1:0] : load_value_i;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_reload <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_reload <= w_reload_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_reload_nxt = r_reload;
        w_tick_nxt   = 1'b0;
        if (load_i) begin
            // A load pre-empts any expiry happening in the same cycle.
            w_cnt_nxt    = w_load_sat;
            w_reload_nxt = w_load_sat;
            if (w_load_sat == c_zero) begin
                w_state_nxt = S_DONE;
                w_tick_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_RUN;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (enable_i) begin
                        if (r_cnt > c_one) begin
                            w_cnt_nxt = r_cnt - c_one;
                        end else begin
                            w_tick_nxt = 1'b1;
                            if (AUTO_RELOAD != 0) begin
                                w_cnt_nxt = r_reload;
                            end else begin
                                w_cnt_nxt   = c_zero;
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: w_cnt_nxt = c_zero;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign counter_val_o = r_cnt;
    assign busy_o        = (r_state == S_RUN);
    assign finished_o    = (r_state == S_DONE);
    assign tick_o        = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
// ============================================================================
// Module      : tb_down_counter
// Description : Randomized and directed bench for down_counter, one-shot and
//               auto-reload instances checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_counter;

    localparam int MAX = 160;
    localparam int W   = $clog2(MAX + 1);

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         load_i;
    logic [W-1:0] load_value_i;
    logic         enable_i;

    logic [W-1:0] cnt_os, cnt_ar;
    logic         busy_os, busy_ar, fin_os, fin_ar, tick_os, tick_ar;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Model state per instance: index 0 one-shot, 1 auto-reload.
    // Phase: 0 idle, 1 counting, 2 expired.
    int m_cnt[2];
    int m_rel[2];
    int m_phase[2];
    int m_tick[2];

    always #5 clock_i = ~clock_i;

    down_counter #(.MAX_COUNTER_VALUE(MAX), .AUTO_RELOAD(0)) u_dut_os (
        .clock_i(clock_i), .reset_i(reset_i), .load_i(load_i),
        .load_value_i(load_value_i), .enable_i(enable_i),
        .counter_val_o(cnt_os), .busy_o(busy_os),
        .finished_o(fin_os), .tick_o(tick_os)
    );

    down_counter #(.MAX_COUNTER_VALUE(MAX), .AUTO_RELOAD(1)) u_dut_ar (
        .clock_i(clock_i), .reset_i(reset_i), .load_i(load_i),
        .load_value_i(load_value_i), .enable_i(enable_i),
        .counter_val_o(cnt_ar), .busy_o(busy_ar),
        .finished_o(fin_ar), .tick_o(tick_ar)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors_applied++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_phase[i] = 0; m_tick[i] = 0;
        end
    endtask

    task automatic model_step(input bit ld, input int val, input bit en);
        int v;
        v = (val > MAX) ? MAX : val;
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 0;
            if (ld) begin
                m_cnt[i] = v;
                m_rel[i] = v;
                m_phase[i] = (v == 0) ? 2 : 1;
                m_tick[i] = (v == 0) ? 1 : 0;
            end else if (m_phase[i] == 1 && en) begin
                if (m_cnt[i] > 1) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end else begin
                    m_tick[i] = 1;
                    if (i == 1) m_cnt[i] = m_rel[i];
                    else begin m_cnt[i] = 0; m_phase[i] = 2; end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("os_cnt",  int'(cnt_os),  m_cnt[0]);
        check("os_busy", int'(busy_os), int'(m_phase[0] == 1));
        check("os_fin",  int'(fin_os),  int'(m_phase[0] == 2));
        check("os_tick", int'(tick_os), m_tick[0]);
        check("ar_cnt",  int'(cnt_ar),  m_cnt[1]);
        check("ar_busy", int'(busy_ar), int'(m_phase[1] == 1));
        check("ar_fin",  int'(fin_ar),  int'(m_phase[1] == 2));
        check("ar_tick", int'(tick_ar), m_tick[1]);
    endtask

    // Called at a falling edge; drives one cycle of stimulus and checks it.
    task automatic cycle(input bit ld, input int val, input bit en);
        load_i       = ld;
        load_value_i = W'(val);
        enable_i     = en;
        @(posedge clock_i);
        model_step(ld, val, en);
        @(negedge clock_i);
        compare_all();
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        load_i = 1'b0; enable_i = 1'b0; load_value_i = '0;
        #1;
        check("rst_cnt_os",  int'(cnt_os),  0);
        check("rst_busy_os", int'(busy_os), 0);
        check("rst_fin_os",  int'(fin_os),  0);
        check("rst_tick_os", int'(tick_os), 0);
        check("rst_cnt_ar",  int'(cnt_ar),  0);
        check("rst_busy_ar", int'(busy_ar), 0);
        model_reset();
        repeat (2) @(negedge clock_i);
        reset_i = 1'b1;
        compare_all();
    endtask

    int n_os, n_ar;

    initial begin
        reset_i = 1'b1;
        load_i = 1'b0; enable_i = 1'b0; load_value_i = '0;
        model_reset();
        @(negedge clock_i);
        do_reset();

        // Enable without a load stays idle.
        repeat (3) cycle(0, 0, 1);

        // One-shot count from 10.
        cycle(1, 10, 1);
        check("load10_cnt", int'(cnt_os), 10);
        n_os = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 1);
            n_os += int'(tick_os);
        end
        check("os10_ticks", n_os, 1);
        check("os10_cnt_end", int'(cnt_os), 0);
        repeat (3) cycle(0, 0, 1);

        // Pause in the middle of a count.
        cycle(1, 6, 1);
        repeat (2) cycle(0, 0, 1);
        repeat (3) cycle(0, 0, 0);
        check("pause_hold", int'(cnt_os), 4);
        repeat (3) cycle(0, 0, 1);
        check("pause_no_early_tick", int'(tick_os), 0);
        cycle(0, 0, 1);
        check("pause_tick", int'(tick_os), 1);

        // Zero load expires immediately in both modes.
        cycle(1, 0, 1);
        check("zero_tick_ar", int'(tick_ar), 1);
        check("zero_fin_ar", int'(fin_ar), 1);
        cycle(0, 0, 1);

        // Out-of-range load saturates.
        cycle(1, 255, 1);
        check("sat_cnt", int'(cnt_os), MAX);
        n_os = 0; n_ar = 0;
        for (int k = 0; k < MAX; k++) begin
            cycle(0, 0, 1);
            n_os += int'(tick_os);
            n_ar += int'(tick_ar);
        end
        check("sat_ticks_os", n_os, 1);
        check("sat_ticks_ar", n_ar, 1);
        check("sat_reload_ar", int'(cnt_ar), MAX);

        // Periodic ticks from auto-reload.
        cycle(1, 4, 1);
        n_ar = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 1);
            n_ar += int'(tick_ar);
        end
        check("ar4_ticks", n_ar, 5);

        // Back-to-back expiry with a period of one.
        cycle(1, 1, 1);
        repeat (5) cycle(0, 0, 1);

        // Load pre-empts expiry.
        cycle(1, 2, 1);
        cycle(0, 0, 1);
        cycle(1, 7, 1);
        check("preempt_cnt", int'(cnt_os), 7);
        check("preempt_tick", int'(tick_os), 0);
        check("preempt_busy", int'(busy_os), 1);

        // Reset abandons a count in progress.
        cycle(1, 9, 1);
        repeat (4) cycle(0, 0, 1);
        check("mid_cnt", int'(cnt_os), 5);
        do_reset();

        // Randomized phase.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                bit ld;
                int v;
                ld = ($urandom_range(0, 15) == 0);
                v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 6));
                cycle(ld, v, ($urandom_range(0, 3) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
